lap_tracker: RTL

LAP_TRACKER -- requirements
Module: lap_tracker

---
 rtl/race_pkg.sv | 54 +++++
 rtl/cs_tick_gen.sv | 31 +++
 rtl/lap_tracker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/race_pkg.sv
// Shared race definitions: game state codes, map size, checkpoint zones and
// the lap checkpoint FSM encoding.
package race_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned POS_W   = 10;
  localparam int unsigned FSM_W   = 3;

  // Game state codes from the state encoder
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETTING   = 3'd1;
  localparam logic [STATE_W-1:0] ST_COUNTDOWN = 3'd3;
  localparam logic [STATE_W-1:0] ST_RACING    = 3'd4;
  localparam logic [STATE_W-1:0] ST_PAUSE     = 3'd5;
  localparam logic [STATE_W-1:0] ST_FINISH    = 3'd6;

  localparam int unsigned MAP_W = 320;
  localparam int unsigned MAP_H = 240;

  typedef struct packed {
    logic [POS_W-1:0] x_lo;
    logic [POS_W-1:0] x_hi;
    logic [POS_W-1:0] y_lo;
    logic [POS_W-1:0] y_hi;
  } zone_t;

  // Inclusive checkpoint rectangles; CP0 is the start/finish line
  localparam zone_t CP0_ZONE = '{x_lo: 10'd140, x_hi: 10'd180, y_lo: 10'd200, y_hi: 10'd239};
  localparam zone_t CP1_ZONE = '{x_lo: 10'd280, x_hi: 10'd319, y_lo: 10'd100, y_hi: 10'd140};
  localparam zone_t CP2_ZONE = '{x_lo: 10'd140, x_hi: 10'd180, y_lo: 10'd0,   y_hi: 10'd39};
  localparam zone_t CP3_ZONE = '{x_lo: 10'd0,   x_hi: 10'd39,  y_lo: 10'd100, y_hi: 10'd140};

  localparam logic [FSM_W-1:0] FSM_WAIT_CP1  = 3'd0;
  localparam logic [FSM_W-1:0] FSM_WAIT_CP2  = 3'd1;
  localparam logic [FSM_W-1:0] FSM_WAIT_CP3  = 3'd2;
  localparam logic [FSM_W-1:0] FSM_WAIT_LINE = 3'd3;
  localparam logic [FSM_W-1:0] FSM_DONE      = 3'd4;

  function automatic logic in_zone(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y,
                                   input zone_t z);
    return (x >= z.x_lo) && (x <= z.x_hi) && (y >= z.y_lo) && (y <= z.y_hi);
  endfunction

  // Checkpoint index reported while waiting in a given FSM state
  function automatic logic [1:0] cp_index(input logic [FSM_W-1:0] s);
    case (s)
      FSM_WAIT_CP1: return 2'd1;
      FSM_WAIT_CP2: return 2'd2;
      FSM_WAIT_CP3: return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cs_tick_gen.sv
// Centisecond prescaler: one-cycle tick every TICKS enabled cycles; holds its
// phase while disabled and restarts from zero on clear.
module cs_tick_gen #(
  parameter int unsigned TICKS = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(TICKS - 1));
  assign tick = enable && !clear && wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lap_tracker.sv
// Lap/checkpoint tracker with lap, race and best-lap timers.
// Best-lap tracking is built only when LAP_TRACKER_BEST_LAP_EN is defined.
module lap_tracker
  import race_pkg::*;
#(
  parameter int unsigned NUM_LAPS     = 3,
  parameter int unsigned TICKS_PER_CS = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   state,
  input  logic [9:0]   pos_x,
  input  logic [9:0]   pos_y,
  output logic [2:0]   lap,
  output logic [1:0]   next_cp,
  output logic [13:0]  lap_time_cs,
  output logic [15:0]  race_time_cs,
  output logic [13:0]  best_lap_cs,
  output logic         lap_done,
  output logic         race_done
);

  logic [FSM_W-1:0] cp_state, cp_state_n;
  logic [2:0]       lap_n;
  logic [1:0]       next_cp_n;
  logic [13:0]      lap_time_n;
  logic [15:0]      race_time_n;
  logic             lap_done_n;
  logic             race_done_n;
  logic             racing, clear_st, tick;

  assign racing   = (state == ST_RACING);
  assign clear_st = (state == ST_IDLE) || (state == ST_SETTING) || (state == ST_COUNTDOWN);

  cs_tick_gen #(.TICKS(TICKS_PER_CS)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (racing),
    .clear  (clear_st),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cp_state     <= FSM_WAIT_CP1;
      lap          <= '0;
      next_cp      <= 2'd1;
      lap_time_cs  <= '0;
      race_time_cs <= '0;
      lap_done     <= 1'b0;
      race_done    <= 1'b0;
    end else begin
      cp_state     <= cp_state_n;
      lap          <= lap_n;
      next_cp      <= next_cp_n;
      lap_time_cs  <= lap_time_n;
      race_time_cs <= race_time_n;
      lap_done     <= lap_done_n;
      race_done    <= race_done_n;
    end
  end

  // Any state code that is neither racing nor a clearing state holds everything
  always_comb begin
    cp_state_n  = cp_state;
    lap_n       = lap;
    lap_time_n  = lap_time_cs;
    race_time_n = race_time_cs;
    lap_done_n  = 1'b0;
    race_done_n = race_done;

    if (clear_st) begin
      cp_state_n  = FSM_WAIT_CP1;
      lap_n       = '0;
      lap_time_n  = '0;
      race_time_n = '0;
      race_done_n = 1'b0;
    end else if (racing && (cp_state != FSM_DONE)) begin
      if (tick) begin
        lap_time_n  = (lap_time_cs == 14'h3FFF) ? lap_time_cs : lap_time_cs + 14'd1;
        race_time_n = (race_time_cs == 16'hFFFF) ? race_time_cs : race_time_cs + 16'd1;
      end
      case (cp_state)
        FSM_WAIT_CP1: if (in_zone(pos_x, pos_y, CP1_ZONE)) cp_state_n = FSM_WAIT_CP2;
        FSM_WAIT_CP2: if (in_zone(pos_x, pos_y, CP2_ZONE)) cp_state_n = FSM_WAIT_CP3;
        FSM_WAIT_CP3: if (in_zone(pos_x, pos_y, CP3_ZONE)) cp_state_n = FSM_WAIT_LINE;
        FSM_WAIT_LINE: begin
          if (in_zone(pos_x, pos_y, CP0_ZONE)) begin
            lap_n      = lap + 3'd1;
            lap_done_n = 1'b1;
            lap_time_n = '0;
            if (lap_n == 3'(NUM_LAPS)) begin
              cp_state_n  = FSM_DONE;
              race_done_n = 1'b1;
            end else begin
              cp_state_n  = FSM_WAIT_CP1;
            end
          end
        end
        default: ;
      endcase
    end

    next_cp_n = cp_index(cp_state_n);
  end

`ifdef LAP_TRACKER_BEST_LAP_EN
  // Compare against the lap time as it stood before the completion clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_lap_cs <= 14'h3FFF;
    end else if (lap_done_n && (lap_time_cs < best_lap_cs)) begin
      best_lap_cs <= lap_time_cs;
    end
  end
`else
  assign best_lap_cs = 14'h3FFF;
`endif

endmodule
